// File: rtl/sync_sample_gen.sv
// rtl/sync_sample_gen.sv - synchronous sampling strobe generator locked to line-frequency zero crossings
module sync_sample_gen #(
  parameter int M_W     = 13,
  parameter int IDX_W   = 10,
  parameter int M_MIN   = 16,
  parameter int TO_W    = 23,
  parameter int TIMEOUT = 4194304
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freq_in,
  input  logic [M_W-1:0]   M,
  output logic             sample_stb,
  output logic [IDX_W-1:0] sample_idx,
  output logic             cycle_done,
  output logic             cycle_short,
  output logic             locked,
  output logic             sig_lost
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_PREV = {{(IDX_W-1){1'b1}}, 1'b0};

  state_t           state, state_n;
  logic             sync1, sync2, sync3;
  logic             zc, m_ok, to_hit, div_last;
  logic [M_W-1:0]   div_reg, div_reg_n, div_cnt, div_cnt_n;
  logic [IDX_W-1:0] idx_n;
  logic [TO_W-1:0]  to_cnt, to_cnt_n;
  logic             stb_n, done_n, short_n, locked_n, lost_n;

  // sync1/sync2 form the synchronizer; sync3 remembers the previous level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= freq_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign zc       = sync2 & ~sync3;
  assign m_ok     = (M >= M_W'(M_MIN));
  assign to_hit   = !zc && (to_cnt == TO_LAST);
  assign div_last = (div_cnt == div_reg - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      div_reg     <= '0;
      div_cnt     <= '0;
      sample_idx  <= '0;
      to_cnt      <= '0;
      sample_stb  <= 1'b0;
      cycle_done  <= 1'b0;
      cycle_short <= 1'b0;
      locked      <= 1'b0;
      sig_lost    <= 1'b0;
    end else begin
      state       <= state_n;
      div_reg     <= div_reg_n;
      div_cnt     <= div_cnt_n;
      sample_idx  <= idx_n;
      to_cnt      <= to_cnt_n;
      sample_stb  <= stb_n;
      cycle_done  <= done_n;
      cycle_short <= short_n;
      locked      <= locked_n;
      sig_lost    <= lost_n;
    end
  end

  // Priority: zero crossing, then loss-of-signal timeout, then regular strobe timing
  always_comb begin
    state_n   = state;
    div_reg_n = div_reg;
    div_cnt_n = div_cnt;
    idx_n     = sample_idx;
    to_cnt_n  = zc ? '0 : ((to_cnt == TO_MAX) ? to_cnt : to_cnt + 1'b1);
    stb_n     = 1'b0;
    done_n    = 1'b0;
    short_n   = 1'b0;
    locked_n  = locked;
    lost_n    = sig_lost;

    if (zc) begin
      if (state == RUN) begin
        short_n  = 1'b1;
        locked_n = 1'b0;
      end
      if (m_ok) begin
        state_n   = RUN;
        div_reg_n = M;
        div_cnt_n = '0;
        idx_n     = '0;
        stb_n     = 1'b1;
        lost_n    = 1'b0;
        if (state == HOLD) locked_n = 1'b1;
      end else begin
        state_n  = IDLE;
        locked_n = 1'b0;
      end
    end else if (to_hit) begin
      lost_n   = 1'b1;
      locked_n = 1'b0;
      state_n  = IDLE;
    end else if (state == RUN) begin
      if (div_last) begin
        div_cnt_n = '0;
        idx_n     = sample_idx + 1'b1;
        stb_n     = 1'b1;
        if (sample_idx == IDX_PREV) begin
          done_n  = 1'b1;
          state_n = HOLD;
        end
      end else begin
        div_cnt_n = div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sync_sample_gen.sv
// tb/tb_sync_sample_gen.sv - randomized bench for sync_sample_gen against a strobe-timing model
module tb_sync_sample_gen;

  localparam int M_W     = 13;
  localparam int IDX_W   = 6;
  localparam int M_MIN   = 16;
  localparam int TO_W    = 23;
  localparam int TIMEOUT = 3000;
  localparam int NSAMP   = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             freq_in = 1'b0;
  logic [M_W-1:0]   M = M_W'(20);
  logic             sample_stb, cycle_done, cycle_short, locked, sig_lost;
  logic [IDX_W-1:0] sample_idx;

  int checks = 0;
  int errors = 0;
  int n_stb = 0, n_done = 0, n_short = 0;

  sync_sample_gen #(
    .M_W(M_W), .IDX_W(IDX_W), .M_MIN(M_MIN), .TO_W(TO_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .freq_in(freq_in), .M(M),
    .sample_stb(sample_stb), .sample_idx(sample_idx), .cycle_done(cycle_done),
    .cycle_short(cycle_short), .locked(locked), .sig_lost(sig_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: strobes sit at t0 + k*div for k < NSAMP, t0 being the edge that saw the crossing
  localparam int MD_IDLE = 0, MD_RUN = 1, MD_DONE = 2;
  int   e, t0, dv, last_zc, mode, idx_m;
  bit   stb_m, done_m, short_m, locked_m, lost_m;
  bit [3:0] f_hist;

  always @(posedge clk) begin
    if (!rst_n) begin
      e = 0; t0 = 0; dv = 1; last_zc = 0; mode = MD_IDLE; idx_m = 0; f_hist = '0;
      stb_m = 0; done_m = 0; short_m = 0; locked_m = 0; lost_m = 0;
    end else begin
      e++;
      f_hist = {f_hist[2:0], freq_in};
      stb_m = 0; done_m = 0; short_m = 0;
      if (f_hist[2] && !f_hist[3]) begin
        short_m = (mode == MD_RUN);
        last_zc = e;
        if (int'(M) >= M_MIN) begin
          locked_m = (mode == MD_DONE);
          lost_m = 0; mode = MD_RUN; t0 = e; dv = int'(M);
          stb_m = 1; idx_m = 0;
        end else begin
          mode = MD_IDLE; locked_m = 0;
        end
      end else if (e - last_zc == TIMEOUT) begin
        lost_m = 1; locked_m = 0; mode = MD_IDLE;
      end else if (mode == MD_RUN && (e - t0) % dv == 0) begin
        idx_m = (e - t0) / dv;
        stb_m = 1;
        if (idx_m == NSAMP - 1) begin
          done_m = 1; mode = MD_DONE;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("pulses", {29'd0, sample_stb, cycle_done, cycle_short}, {29'd0, stb_m, done_m, short_m});
    chk("levels", {30'd0, locked, sig_lost}, {30'd0, locked_m, lost_m});
    chk("idx", 32'(sample_idx), 32'(idx_m));
    n_stb   += int'(sample_stb);
    n_done  += int'(cycle_done);
    n_short += int'(cycle_short);
  end

  task automatic wait_clks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One freq_in period starting with a rising edge; M may be swapped partway through
  task automatic pulse(input int period, input int m_at, input int m_new);
    for (int i = 0; i < period; i++) begin
      @(negedge clk);
      freq_in = (i < period / 2);
      if (i == m_at) M = M_W'(m_new);
    end
  endtask

  int s_stb, s_done, s_short;

  initial begin
    wait_clks(3);
    @(negedge clk); #2 rst_n = 1'b1;

    // Static input: only the loss-of-signal timeout should fire
    s_stb = n_stb;
    wait_clks(TIMEOUT + 20);
    chk("lost_after_timeout", 32'(sig_lost), 32'd1);
    chk("no_strobes_static", 32'(n_stb - s_stb), 32'd0);

    // Nominal cycles with a 20-clock hold gap
    M = M_W'(20);
    s_done = n_done; s_stb = n_stb;
    for (int k = 0; k < 3; k++) pulse(NSAMP * 20 + 20, -1, 0);
    wait_clks(NSAMP * 20 + 100);
    chk("nominal_done_count", 32'(n_done - s_done), 32'd3);
    chk("nominal_stb_count", 32'(n_stb - s_stb), 32'(3 * NSAMP));
    chk("nominal_locked", 32'(locked), 32'd1);

    // Short cycles
    s_short = n_short;
    for (int k = 0; k < 3; k++) pulse(1000, -1, 0);
    chk("short_count", 32'(n_short - s_short), 32'd2);
    chk("short_unlocked", 32'(locked), 32'd0);
    wait_clks(NSAMP * 20 + 100);

    // M change mid-cycle takes effect only at the next edge
    pulse(NSAMP * 20 + 20, 300, 25);
    pulse(NSAMP * 25 + 30, -1, 0);
    M = M_W'(20);

    // Edge lands exactly on a due strobe
    for (int k = 0; k < 3; k++) pulse(20 * 40, -1, 0);

    // Invalid M, timeout, then recovery
    M = M_W'(8);
    pulse(600, -1, 0);
    wait_clks(TIMEOUT);
    chk("lost_invalid_m", 32'(sig_lost), 32'd1);
    M = M_W'(20);
    pulse(600, -1, 0);
    chk("lost_cleared", 32'(sig_lost), 32'd0);

    // Randomized periods and divide numbers
    for (int k = 0; k < 24; k++) begin
      int per;
      per = $urandom_range(300, 2200);
      M = M_W'($urandom_range(12, 30));
      pulse(per, $urandom_range(0, per + 50), $urandom_range(12, 30));
      if ($urandom_range(0, 7) == 0) wait_clks(TIMEOUT);
    end

    // Asynchronous reset in the middle of a running cycle
    M = M_W'(20);
    pulse(400, -1, 0);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs",
           {25'd0, sample_stb, cycle_done, cycle_short, locked, sig_lost, 2'd0} | 32'(sample_idx),
           32'd0);
    wait_clks(3);
    @(negedge clk); #2 rst_n = 1'b1;
    for (int k = 0; k < 2; k++) pulse(NSAMP * 20 + 20, -1, 0);
    wait_clks(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
